adder_led_arbiter: RTL and testbench

//  Round-robin controller sharing one 2-bit adder and its 6-LED bar between two requesters.

---
 rtl/adder_led_arbiter.sv | 146 ++++++++++++++
 tb/tb_adder_led_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/adder_led_arbiter.sv
// Round-robin sharing of one 2-bit adder and its 6-LED thermometer bar between two requesters.
// Latency: req seen at E0 -> operands after E0 -> leds after E1 -> ack after E(1+HOLD_CYCLES).
// Backpressure: four-phase req/ack; the non-owner waits while busy, ack held until owner drops req.
module adder_led_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [1:0] a0,
  input  logic [1:0] b0,
  output logic       ack0,
  input  logic       req1,
  input  logic [1:0] a1,
  input  logic [1:0] b1,
  output logic       ack1,
  output logic [1:0] sayi1,
  output logic [1:0] sayi2,
  input  logic [2:0] toplam,
  output logic [5:0] leds,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SHOW, S_ACK} state_t;

  state_t           r_state, w_state;
  logic [1:0]       r_sayi1, w_sayi1;
  logic [1:0]       r_sayi2, w_sayi2;
  logic [5:0]       r_leds, w_leds;
  logic             r_ack0, w_ack0;
  logic             r_ack1, w_ack1;
  logic             r_busy, w_busy;
  logic             r_owner, w_owner;
  logic             r_last, w_last;
  logic [CNT_W-1:0] r_cnt, w_cnt;

  logic             w_grant;
  logic             w_req_own;

  // Sum to thermometer code; 7 is unreachable from a 2+2-bit add and saturates.
  function automatic logic [5:0] therm(input logic [2:0] s);
    case (s)
      3'd0:    therm = 6'b000000;
      3'd1:    therm = 6'b000001;
      3'd2:    therm = 6'b000011;
      3'd3:    therm = 6'b000111;
      3'd4:    therm = 6'b001111;
      3'd5:    therm = 6'b011111;
      default: therm = 6'b111111;
    endcase
  endfunction

  // Arbitration: on a tie the requester that was not served last wins.
  always_comb begin
    w_grant   = (req0 && req1) ? ~r_last : req1;
    w_req_own = r_owner ? req1 : req0;
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    w_state = r_state;
    w_sayi1 = r_sayi1;
    w_sayi2 = r_sayi2;
    w_leds  = r_leds;
    w_ack0  = r_ack0;
    w_ack1  = r_ack1;
    w_busy  = r_busy;
    w_owner = r_owner;
    w_last  = r_last;
    w_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_owner = w_grant;
          w_sayi1 = w_grant ? a1 : a0;
          w_sayi2 = w_grant ? b1 : b0;
          w_busy  = 1'b1;
          w_state = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_leds  = therm(toplam);
        w_cnt   = CNT_W'(HOLD_CYCLES - 1);
        w_state = S_SHOW;
      end
      S_SHOW: begin
        if (r_cnt == '0) begin
          w_ack0  = ~r_owner;
          w_ack1  = r_owner;
          w_last  = r_owner;
          w_state = S_ACK;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_ACK: begin
        // An owner that already dropped req gets a one-cycle ack pulse.
        if (!w_req_own) begin
          w_ack0  = 1'b0;
          w_ack1  = 1'b0;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sayi1 <= '0;
      r_sayi2 <= '0;
      r_leds  <= '0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b0;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_sayi1 <= w_sayi1;
      r_sayi2 <= w_sayi2;
      r_leds  <= w_leds;
      r_ack0  <= w_ack0;
      r_ack1  <= w_ack1;
      r_busy  <= w_busy;
      r_owner <= w_owner;
      r_last  <= w_last;
      r_cnt   <= w_cnt;
    end
  end

  assign sayi1 = r_sayi1;
  assign sayi2 = r_sayi2;
  assign leds  = r_leds;
  assign ack0  = r_ack0;
  assign ack1  = r_ack1;
  assign busy  = r_busy;
  assign owner = r_owner;

endmodule

// File: tb/tb_adder_led_arbiter.sv
// Directed bench for adder_led_arbiter with a behavioural shared adder.
// Latency: checks every edge of each transaction against hand-derived timing.
// Backpressure: drives four-phase req/ack from both requester sides.
module tb_adder_led_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       ack0, ack1, busy, owner;
  logic [1:0] sayi1, sayi2;
  logic [2:0] toplam;
  logic [5:0] leds;
  logic       force7 = 1'b0;

  int checks   = 0;
  int failures = 0;

  adder_led_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .a1(a1), .b1(b1), .ack1(ack1),
    .sayi1(sayi1), .sayi2(sayi2), .toplam(toplam),
    .leds(leds), .busy(busy), .owner(owner)
  );

  // Shared combinational adder, with an override to inject an impossible sum.
  assign toplam = force7 ? 3'd7 : ({1'b0, sayi1} + {1'b0, sayi2});

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
  endtask

  function automatic logic [5:0] therm(input int s);
    therm = (s >= 6) ? 6'b111111 : 6'((1 << s) - 1);
  endfunction

  // One full transaction for requester `who`, whose req is already high and FSM in IDLE.
  task automatic txn(input string tag, input int who, input logic [1:0] ea, input logic [1:0] eb,
                     input logic [5:0] eleds);
    tick();                                          // E0 grant
    chk({tag, "_owner"}, 32'(owner), 32'(who));
    chk({tag, "_sayi1"}, 32'(sayi1), 32'(ea));
    chk({tag, "_sayi2"}, 32'(sayi2), 32'(eb));
    chk({tag, "_busy"},  32'(busy),  32'd1);
    tick();                                          // E1 capture
    chk({tag, "_leds"},  32'(leds),  32'(eleds));
    repeat (3) tick();                               // E2..E4
    chk({tag, "_ack_early"}, 32'(ack0 | ack1), 32'd0);
    tick();                                          // E5
    chk({tag, "_ack_own"}, 32'(who ? ack1 : ack0), 32'd1);
    chk({tag, "_ack_oth"}, 32'(who ? ack0 : ack1), 32'd0);
    if (who == 1) req1 = 1'b0; else req0 = 1'b0;
    tick();
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done_ack"},  32'(ack0 | ack1), 32'd0);
    chk({tag, "_leds_hold"}, 32'(leds), 32'(eleds));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_sayi1", 32'(sayi1), 32'd0);
    chk("rst_sayi2", 32'(sayi2), 32'd0);
    chk("rst_leds",  32'(leds),  32'd0);
    chk("rst_acks",  32'({ack1, ack0}), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Test 1: single requester 2+3, operands change after grant, ack held while req high
    req0 = 1'b1; a0 = 2'd2; b0 = 2'd3;
    tick();
    chk("t1_sayi1", 32'(sayi1), 32'd2);
    chk("t1_sayi2", 32'(sayi2), 32'd3);
    chk("t1_leds_pre", 32'(leds), 32'd0);
    a0 = 2'd0; b0 = 2'd0;
    tick();
    chk("t1_leds", 32'(leds), 32'(6'b011111));
    repeat (3) tick();
    chk("t1_ack_E4", 32'(ack0), 32'd0);
    tick();
    chk("t1_ack_E5", 32'(ack0), 32'd1);
    tick();
    chk("t1_ack_held", 32'(ack0), 32'd1);
    chk("t1_busy_held", 32'(busy), 32'd1);
    req0 = 1'b0;
    tick();
    chk("t1_ack_drop", 32'(ack0), 32'd0);
    chk("t1_busy_drop", 32'(busy), 32'd0);
    chk("t1_leds_hold", 32'(leds), 32'(6'b011111));
    chk("t1_sayi_hold", 32'({sayi1, sayi2}), 32'({2'd2, 2'd3}));

    // Test 2: tie from reset -> 0 then 1, then 0 again
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req0 = 1'b1; a0 = 2'd1; b0 = 2'd1;
    req1 = 1'b1; a1 = 2'd3; b1 = 2'd2;
    txn("t2a", 0, 2'd1, 2'd1, 6'b000011);
    txn("t2b", 1, 2'd3, 2'd2, 6'b011111);
    req0 = 1'b1; req1 = 1'b1;
    txn("t2c", 0, 2'd1, 2'd1, 6'b000011);
    txn("t2d", 1, 2'd3, 2'd2, 6'b011111);

    // Test 3: all 16 operand pairs on requester 1
    for (int i = 0; i < 16; i++) begin
      a1 = 2'(i >> 2); b1 = 2'(i & 3);
      req1 = 1'b1;
      txn($sformatf("t3_%0d", i), 1, 2'(i >> 2), 2'(i & 3), therm((i >> 2) + (i & 3)));
    end

    // Test 4: impossible sum 7 saturates
    force7 = 1'b1;
    a1 = 2'd0; b1 = 2'd0; req1 = 1'b1;
    txn("t4", 1, 2'd0, 2'd0, 6'b111111);
    force7 = 1'b0;

    // Test 5: reset in SHOW, then req1 re-arbitrated
    a1 = 2'd1; b1 = 2'd2; req1 = 1'b1;
    repeat (3) tick();
    chk("t5_busy_show", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", 32'({sayi1, sayi2, leds, ack0, ack1, busy, owner}), 32'd0);
    rst = 1'b0;
    txn("t5", 1, 2'd1, 2'd2, 6'b000111);

    // Test 6: owner drops req in SHOW -> one-cycle ack, pending req1 then granted
    a0 = 2'd1; b0 = 2'd0; req0 = 1'b1;
    a1 = 2'd2; b1 = 2'd2; req1 = 1'b1;
    tick();
    chk("t6_owner0", 32'(owner), 32'd0);
    tick();
    chk("t6_leds0", 32'(leds), 32'(6'b000001));
    tick();
    req0 = 1'b0;
    repeat (2) tick();
    chk("t6_ack_E4", 32'(ack0), 32'd0);
    tick();
    chk("t6_ack_E5", 32'(ack0), 32'd1);
    tick();
    chk("t6_ack_pulse", 32'(ack0), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    txn("t6b", 1, 2'd2, 2'd2, 6'b001111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
